fetch_unit: RTL and testbench

Instruction fetch front end for the RV32I pipeline. It generates the PC, issues in-order requests to instruction memory, buffers returned words, and presents `{pc_pre_address, instruction_fetch}` to the IF/ID pipeline register each cycle. It obeys the two control inputs the IF/ID stage already reacts to: taken-control-flow redirect (Jal/Jalr/branch) and load-use stall. Stale responses from before a redirect are discarded with a 2-bit epoch tag.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory request/response bus between the fetch front end and
//   instruction memory.
//
//   req     fetch -> mem   request valid
//   addr    fetch -> mem   byte address of the requested word (4-aligned)
//   ready   mem -> fetch   memory accepts the request this cycle
//   rvalid  mem -> fetch   response valid (in order, >= 1 cycle after accept)
//   rdata   mem -> fetch   response instruction word
//
//   modport master : fetch side
//   modport slave  : memory side
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   RV32I instruction fetch front end. Generates the PC, issues in-order word
//   requests to instruction memory, buffers returned words and presents the
//   oldest one to the IF/ID register. Taken control flow (redirect) flushes the
//   output buffer and bumps a 2-bit epoch; responses tagged with an older epoch
//   are dropped when they return. A load-use stall holds the presented word.
//
//   Ports
//     clk, rst           clock, asynchronous active-high reset
//     redirect           taken Jal/Jalr/branch this cycle
//     redirect_pc        redirect target
//     stall              downstream does not consume this cycle
//     imem               instruction memory bus (fetch_unit_if.master)
//     instruction_fetch  instruction to IF/ID (0 when fetch_valid = 0)
//     pc_pre_address     PC of that instruction (0 when fetch_valid = 0)
//     fetch_valid        outputs hold a real instruction
//     misalign           sticky misaligned-redirect flag
//
//   Build option
//     FETCH_MISALIGN_TRAP_EN : a redirect to a non-word-aligned target sets the
//     sticky misalign flag and blocks fetch until an aligned redirect. Without
//     it the target is forced to word alignment and misalign is tied to 0.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    fetch_unit_if.master imem,
    output logic [31:0]  instruction_fetch,
    output logic [31:0]  pc_pre_address,
    output logic         fetch_valid,
    output logic         misalign
);

    // Control state (reset)
    logic [31:0] pc_q, pc_d;
    logic [1:0]  epoch_q, epoch_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  buffered_q, buffered_d;
    logic        inf_rd_q, inf_rd_d;
    logic        inf_wr_q, inf_wr_d;
    logic        buf_rd_q, buf_rd_d;
    logic        buf_wr_q, buf_wr_d;

    // Storage (not reset; only read behind a non-zero count)
    logic [31:0] inf_addr_q  [2];
    logic [31:0] inf_addr_d  [2];
    logic [1:0]  inf_epoch_q [2];
    logic [1:0]  inf_epoch_d [2];
    logic [31:0] buf_addr_q  [2];
    logic [31:0] buf_addr_d  [2];
    logic [31:0] buf_data_q  [2];
    logic [31:0] buf_data_d  [2];

    logic        trap_active;
    logic [31:0] redirect_tgt;
    logic        credit_ok;
    logic        issue;
    logic        resp;
    logic        resp_keep;
    logic        pop_out;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    // Each redirect re-evaluates the flag, so an aligned redirect clears it.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect) begin
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign trap_active  = misalign_q;
    assign redirect_tgt = redirect_pc;
`else
    assign trap_active  = 1'b0;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign misalign = trap_active;

    // Handshake and output decode. Credits come from registered counts only,
    // so a pop this cycle does not free a slot until the next one.
    always_comb begin
        credit_ok         = ({1'b0, inflight_q} + {1'b0, buffered_q}) < 3'd2;
        imem.req          = !rst && !redirect && !trap_active && credit_ok;
        imem.addr         = pc_q;
        issue             = imem.req && imem.ready;
        resp              = imem.rvalid && (inflight_q != 2'd0);
        resp_keep         = resp && (inf_epoch_q[inf_rd_q] == epoch_q) && !redirect;
        fetch_valid       = (buffered_q != 2'd0);
        pop_out           = fetch_valid && !stall && !redirect;
        instruction_fetch = fetch_valid ? buf_data_q[buf_rd_q] : 32'h0;
        pc_pre_address    = fetch_valid ? buf_addr_q[buf_rd_q] : 32'h0;
    end

    always_comb begin
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        inflight_d  = inflight_q;
        buffered_d  = buffered_q;
        inf_rd_d    = inf_rd_q;
        inf_wr_d    = inf_wr_q;
        buf_rd_d    = buf_rd_q;
        buf_wr_d    = buf_wr_q;
        inf_addr_d  = inf_addr_q;
        inf_epoch_d = inf_epoch_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;

        // In-flight FIFO: pops on every response, even stale ones.
        if (issue) begin
            inf_addr_d[inf_wr_q]  = pc_q;
            inf_epoch_d[inf_wr_q] = epoch_q;
            inf_wr_d              = ~inf_wr_q;
        end
        if (resp) begin
            inf_rd_d = ~inf_rd_q;
        end
        case ({issue, resp})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        // Output buffer: a redirect empties it outright.
        if (redirect) begin
            buffered_d = 2'd0;
            buf_rd_d   = 1'b0;
            buf_wr_d   = 1'b0;
        end else begin
            if (resp_keep) begin
                buf_addr_d[buf_wr_q] = inf_addr_q[inf_rd_q];
                buf_data_d[buf_wr_q] = imem.rdata;
                buf_wr_d             = ~buf_wr_q;
            end
            if (pop_out) begin
                buf_rd_d = ~buf_rd_q;
            end
            case ({resp_keep, pop_out})
                2'b10:   buffered_d = buffered_q + 2'd1;
                2'b01:   buffered_d = buffered_q - 2'd1;
                default: buffered_d = buffered_q;
            endcase
        end

        if (redirect) begin
            pc_d    = redirect_tgt;
            epoch_d = epoch_q + 2'd1;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            epoch_q    <= 2'd0;
            inflight_q <= 2'd0;
            buffered_q <= 2'd0;
            inf_rd_q   <= 1'b0;
            inf_wr_q   <= 1'b0;
            buf_rd_q   <= 1'b0;
            buf_wr_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
            buffered_q <= buffered_d;
            inf_rd_q   <= inf_rd_d;
            inf_wr_q   <= inf_wr_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        inf_addr_q  <= inf_addr_d;
        inf_epoch_q <= inf_epoch_d;
        buf_addr_q  <= buf_addr_d;
        buf_data_q  <= buf_data_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instruction_fetch;
    logic [31:0] pc_pre_address;
    logic        fetch_valid;
    logic        misalign;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .stall             (stall),
        .imem              (imem),
        .instruction_fetch (instruction_fetch),
        .pc_pre_address    (pc_pre_address),
        .fetch_valid       (fetch_valid),
        .misalign          (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t       mq[$];
    int          lat  = 1;
    int          cyc  = 0;
    bit          spur = 1'b0;
    logic        acc_s;
    logic [31:0] acc_a;

    always @(negedge clk) begin
        acc_s = imem.req && imem.ready;
        acc_a = imem.addr;
    end

    initial begin
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (acc_s === 1'b1) mq.push_back('{a: acc_a, due: cyc - 1 + lat});
            #1;
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mq[0].a ^ K;
                void'(mq.pop_front());
            end else if (spur) begin
                imem.rvalid = 1'b1;
                imem.rdata  = 32'hDEAD_BEEF;
            end else begin
                imem.rvalid = 1'b0;
                imem.rdata  = 32'h0;
            end
        end
    end

    // ---------------- behavioural fetch model ----------------
    typedef struct { logic [31:0] a; logic [1:0] e; } inf_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } ob_t;
    inf_t        m_inf[$];
    ob_t         m_buf[$];
    logic [31:0] m_pc;
    logic [1:0]  m_ep;
    logic        m_mis;
    logic        m_acc, m_keep, m_pop;
    inf_t        m_h;

    function automatic logic model_req();
        return !rst && !redirect && !m_mis && ((m_inf.size() + m_buf.size()) < 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc  = 32'h0;
            m_ep  = 2'd0;
            m_mis = 1'b0;
            m_inf.delete();
            m_buf.delete();
        end else begin
            m_acc  = model_req() && imem.ready;
            m_pop  = (m_buf.size() != 0) && !stall && !redirect;
            m_keep = 1'b0;
            if (imem.rvalid && m_inf.size() != 0) begin
                m_h    = m_inf.pop_front();
                m_keep = (m_h.e == m_ep) && !redirect;
            end
            if (m_acc) m_inf.push_back('{a: m_pc, e: m_ep});
            if (redirect) begin
                m_buf.delete();
            end else begin
                if (m_pop) void'(m_buf.pop_front());
                if (m_keep) m_buf.push_back('{a: m_h.a, d: imem.rdata});
            end
            if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc  = redirect_pc;
                m_mis = (redirect_pc[1:0] != 2'b00);
`else
                m_pc  = {redirect_pc[31:2], 2'b00};
`endif
                m_ep  = m_ep + 2'd1;
            end else if (m_acc) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] cons_a[$];
    logic [31:0] cons_d[$];

    always @(negedge clk) begin
        chk("imem_req", imem.req, model_req());
        chk("imem_addr", imem.addr, m_pc);
        chk("fetch_valid", fetch_valid, m_buf.size() != 0);
        chk("instruction_fetch", instruction_fetch, (m_buf.size() != 0) ? m_buf[0].d : 32'h0);
        chk("pc_pre_address", pc_pre_address, (m_buf.size() != 0) ? m_buf[0].a : 32'h0);
        chk("misalign", misalign, m_mis);
        if (fetch_valid === 1'b1) chk("data_vs_pc", instruction_fetch, pc_pre_address ^ K);
        if (!rst && m_buf.size() != 0 && !stall && !redirect) begin
            cons_a.push_back(m_buf[0].a);
            cons_d.push_back(m_buf[0].d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cons();
        cons_a.delete();
        cons_d.delete();
    endtask

    task automatic expect_cons(input string name, input logic [31:0] a0, input logic [31:0] a1);
        int k;
        k = 0;
        while (cons_a.size() < 2 && k < 40) begin
            step();
            k++;
        end
        chk({name, "_count_ok"}, cons_a.size() >= 2, 1'b1);
        chk({name, "_first"}, (cons_a.size() > 0) ? cons_a[0] : 32'hFFFF_FFFF, a0);
        chk({name, "_second"}, (cons_a.size() > 1) ? cons_a[1] : 32'hFFFF_FFFF, a1);
    endtask

    initial begin
        int k;
        int nacc;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        imem.ready  = 1'b1;

        // Reset state, then zero-wait streaming
        repeat (3) step();
        @(negedge clk);
        chk("rst_req", imem.req, 1'b0);
        chk("rst_fv", fetch_valid, 1'b0);
        chk("rst_pc", pc_pre_address, 32'h0);
        chk("rst_ins", instruction_fetch, 32'h0);
        chk("rst_mis", misalign, 1'b0);
        step();
        rst = 1'b0;
        clear_cons();
        @(negedge clk);
        chk("first_req", imem.req, 1'b1);
        chk("first_addr", imem.addr, 32'h0);
        expect_cons("stream", 32'h0, 32'h4);
        chk("stream_data0", (cons_d.size() > 0) ? cons_d[0] : 32'h0, 32'hA5A5_0000);
        chk("stream_data1", (cons_d.size() > 1) ? cons_d[1] : 32'h0, 32'hA5A5_0004);

        // Stall 3 cycles with PC 8 at the head
        k = 0;
        while (!(m_buf.size() != 0 && m_buf[0].a == 32'h8) && k < 20) begin
            step();
            k++;
        end
        chk("stall_sync", m_buf.size() != 0 && m_buf[0].a == 32'h8, 1'b1);
        stall = 1'b1;
        clear_cons();
        nacc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_fv", fetch_valid, 1'b1);
            chk("stall_pc", pc_pre_address, 32'h8);
            chk("stall_ins", instruction_fetch, 32'hA5A5_0008);
            if (imem.req && imem.ready) nacc++;
            step();
        end
        chk("stall_req_le2", nacc <= 2, 1'b1);
        stall = 1'b0;
        expect_cons("after_stall", 32'h8, 32'hC);

        // Redirect with two requests in flight (2-cycle memory)
        rst = 1'b1;
        lat = 2;
        repeat (3) step();
        rst = 1'b0;
        k = 0;
        while (m_inf.size() != 2 && k < 20) begin
            step();
            k++;
        end
        chk("two_inflight", m_inf.size() == 2, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        clear_cons();
        @(negedge clk);
        chk("redir_cycle_req", imem.req, 1'b0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_r1_fv", fetch_valid, 1'b0);
        chk("redir_r1_req", imem.req, 1'b1);
        chk("redir_r1_addr", imem.addr, 32'h0000_0100);
        expect_cons("redir", 32'h100, 32'h104);

        // Back-to-back redirects
        lat = 1;
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        clear_cons();
        step();
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        expect_cons("b2b", 32'h300, 32'h304);

        // Redirect together with stall and a returning response
        k = 0;
        while (!(m_inf.size() == 1 && m_buf.size() == 1) && k < 20) begin
            step();
            k++;
        end
        chk("rs_sync", m_inf.size() == 1 && m_buf.size() == 1, 1'b1);
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0400;
        clear_cons();
        @(negedge clk);
        chk("rs_rvalid", imem.rvalid, 1'b1);
        chk("rs_fv_before", fetch_valid, 1'b1);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        chk("rs_fv", fetch_valid, 1'b0);
        chk("rs_req", imem.req, 1'b1);
        chk("rs_addr", imem.addr, 32'h0000_0400);
        expect_cons("rs", 32'h400, 32'h404);

        // Misaligned redirect target
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        clear_cons();
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_flag", misalign, 1'b1);
            chk("mis_req", imem.req, 1'b0);
            step();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0104;
        clear_cons();
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("mis_clear", misalign, 1'b0);
        expect_cons("mis_fetch", 32'h104, 32'h108);
`else
        @(negedge clk);
        chk("mis_addr", imem.addr, 32'h0000_0100);
        chk("mis_flag", misalign, 1'b0);
        expect_cons("mis_fetch", 32'h100, 32'h104);
`endif

        // Reset mid-operation, then a response with nothing in flight
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_fv", fetch_valid, 1'b0);
        chk("mid_rst_req", imem.req, 1'b0);
        chk("mid_rst_pc", pc_pre_address, 32'h0);
        chk("mid_rst_ins", instruction_fetch, 32'h0);
        step();
        step();
        imem.ready = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        step();
        @(negedge clk);
        chk("spur_fv", fetch_valid, 1'b0);
        chk("spur_req", imem.req, 1'b1);
        step();
        imem.ready = 1'b1;
        clear_cons();
        expect_cons("post_rst", 32'h0, 32'h4);
        chk("post_rst_data", (cons_d.size() > 0) ? cons_d[0] : 32'h0, 32'hA5A5_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
